// File: rtl/sign_compressor_if.sv
// Handshake bundle for sign_compressor: upstream word in, narrowed word out,
// plus the overflow counter clear and count.
interface sign_compressor_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
);
  // Both sides use valid/ready: a transfer happens on a rising clk edge where
  // valid && ready are both high; valid and its data hold until that edge.
  logic             i_valid;
  logic             o_ready;
  logic [IN_W-1:0]  i_A;
  logic             o_valid;
  logic             i_ready;
  logic [OUT_W-1:0] o_Z;
  logic             o_ovf;
  logic             i_clr;
  logic [CNT_W-1:0] o_ovf_cnt;

  modport slave (
    input  i_valid, i_A, i_ready, i_clr,
    output o_ready, o_valid, o_Z, o_ovf, o_ovf_cnt
  );

  modport master (
    output i_valid, i_A, i_ready, i_clr,
    input  o_ready, o_valid, o_Z, o_ovf, o_ovf_cnt
  );
endinterface

// File: rtl/sign_compressor.sv
// Registered signed narrowing stage (IN_W -> OUT_W) with a 2-entry skid buffer
// and a saturating overflow counter. Define SIGN_COMPRESSOR_WRAP_EN to truncate.
module sign_compressor #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sign_compressor_if.slave  bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [OUT_W-1:0]  out_z;
  logic              out_ovf;
  logic [OUT_W-1:0]  skid_z;
  logic              skid_ovf;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              consume;
  logic              fit;
  logic [OUT_W-1:0]  new_z;
  logic [IN_W-OUT_W:0] top_bits;
  logic              load_new_out;
  logic              load_skid_out;
  logic              load_skid;

  // o_ready decodes only the state register, so i_ready never reaches it.
  assign bus.o_ready   = (state != TWO);
  assign bus.o_valid   = (state != EMPTY);
  assign bus.o_Z       = out_z;
  assign bus.o_ovf     = out_ovf;
  assign bus.o_ovf_cnt = cnt;
  assign dbg_state     = state;

  assign accept  = bus.i_valid && bus.o_ready;
  assign consume = bus.o_valid && bus.i_ready;

  // The word fits when every bit from the sign down to bit OUT_W-1 agrees.
  assign top_bits = bus.i_A[IN_W-1:OUT_W-1];
  assign fit      = (&top_bits) || !(|top_bits);

  always_comb begin
    new_z = bus.i_A[OUT_W-1:0];
`ifdef SIGN_COMPRESSOR_WRAP_EN
    new_z = bus.i_A[OUT_W-1:0];
`else
    if (!fit) begin
      new_z = bus.i_A[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                              : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_nxt     = state;
    load_new_out  = 1'b0;
    load_skid_out = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_new_out = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_new_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          load_skid_out = 1'b1;
          state_nxt     = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_z    <= '0;
      out_ovf  <= 1'b0;
      skid_z   <= '0;
      skid_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_new_out) begin
        out_z   <= new_z;
        out_ovf <= !fit;
      end else if (load_skid_out) begin
        out_z   <= skid_z;
        out_ovf <= skid_ovf;
      end
      if (load_skid) begin
        skid_z   <= new_z;
        skid_ovf <= !fit;
      end
    end
  end

  // Clear has priority over a same-cycle overflow; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.i_clr) begin
      cnt <= '0;
    end else if (accept && !fit && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sign_compressor.sv
// Randomised scoreboard bench for sign_compressor: integer reference model,
// expected queue popped by an output monitor, and a counter model.
module tb_sign_compressor;
  localparam int IN_W    = 8;
  localparam int OUT_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  sign_compressor_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  sign_compressor #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int               checks    = 0;
  int               errors    = 0;
  int               pops      = 0;
  int               exp_cnt   = 0;
  int               ready_pct = 100;
  logic [OUT_W:0]   exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer range test, then clamp (or keep low bits when wrapping).
  function automatic logic [OUT_W:0] ref_out(input logic [IN_W-1:0] a);
    int   v;
    int   hi;
    int   lo;
    int   z;
    logic ovf;
    v   = $signed(a);
    hi  = (1 << (OUT_W - 1)) - 1;
    lo  = -(1 << (OUT_W - 1));
    ovf = (v > hi) || (v < lo);
    z   = v;
`ifndef SIGN_COMPRESSOR_WRAP_EN
    if (v > hi) z = hi;
    else if (v < lo) z = lo;
`endif
    return {z[OUT_W-1:0], ovf};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [IN_W-1:0] a, output int waited);
    int n;
    n           = 0;
    bus.i_valid = 1'b1;
    bus.i_A     = a;
    @(negedge clk);
    while (!bus.o_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=o_ready_low required=accept_within_200");
    end else begin
      exp_q.push_back(ref_out(a));
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    waited      = n;
  endtask

  initial begin
    bus.i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Output monitor: pops on every consume, and checks hold-stability under stall.
  initial begin
    logic [OUT_W:0] hold;
    logic [OUT_W:0] e;
    logic           stall;
    stall = 1'b0;
    hold  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(bus.o_valid), 32'(1'b1));
          check("hold_data", 32'({bus.o_Z, bus.o_ovf}), 32'(hold));
        end
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=no_output", {bus.o_Z, bus.o_ovf});
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'({bus.o_Z, bus.o_ovf}), 32'(e));
          end
          pops++;
          stall = 1'b0;
        end else if (bus.o_valid) begin
          stall = 1'b1;
          hold  = {bus.o_Z, bus.o_ovf};
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  // Counter model: compare, then predict the value after the coming edge.
  initial begin
    logic [OUT_W:0] r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt = 0;
      end else begin
        check("ovf_cnt", 32'(bus.o_ovf_cnt), exp_cnt);
        r = ref_out(bus.i_A);
        if (bus.i_clr) exp_cnt = 0;
        else if (bus.i_valid && bus.o_ready && r[0] && exp_cnt < CNT_MAX) exp_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int total;
    int pops0;
    int bound;
    logic [IN_W-1:0] a;
    rst_n       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_A     = '0;
    bus.i_clr   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.o_valid), 32'(1'b0));
    check("rst_ready", 32'(bus.o_ready), 32'(1'b1));
    check("rst_z", 32'(bus.o_Z), 32'(4'b0000));
    check("rst_ovf", 32'(bus.o_ovf), 32'(1'b0));
    check("rst_cnt", 32'(bus.o_ovf_cnt), 32'(8'd0));
    #21 rst_n = 1'b1;
    step(2);

    // Directed fit and clamp cases, output visible one cycle after acceptance
    send_word(8'hF9, w);
    check("lat_valid_f9", 32'(bus.o_valid), 32'(1'b1));
    check("z_f9", 32'({bus.o_Z, bus.o_ovf}), 32'({4'b1001, 1'b0}));
    send_word(8'h05, w);
    check("z_05", 32'({bus.o_Z, bus.o_ovf}), 32'({4'b0101, 1'b0}));
    send_word(8'h08, w);
`ifdef SIGN_COMPRESSOR_WRAP_EN
    check("z_08", 32'({bus.o_Z, bus.o_ovf}), 32'({4'b1000, 1'b1}));
`else
    check("z_08", 32'({bus.o_Z, bus.o_ovf}), 32'({4'b0111, 1'b1}));
`endif
    send_word(8'h80, w);
`ifdef SIGN_COMPRESSOR_WRAP_EN
    check("z_80", 32'({bus.o_Z, bus.o_ovf}), 32'({4'b0000, 1'b1}));
`else
    check("z_80", 32'({bus.o_Z, bus.o_ovf}), 32'({4'b1000, 1'b1}));
`endif
    step(3);

    // Full-throughput sweep
    total = 0;
    pops0 = pops;
    for (int i = 0; i < 16; i++) begin
      a = 8'hF8 + 8'(i);
      send_word(a, w);
      total += w;
    end
    @(negedge clk);
    #1;
    check("sweep_stalls", total, 0);
    check("sweep_outputs", pops - pops0, 16);
    step(2);

    // Backpressure: two accepts fill the buffer, then release
    ready_pct = 0;
    step(2);
    send_word(8'h00, w);
    send_word(8'h01, w);
    check("bp_ready_low", 32'(bus.o_ready), 32'(1'b0));
    check("bp_valid", 32'(bus.o_valid), 32'(1'b1));
    check("bp_z_head", 32'(bus.o_Z), 32'(4'b0000));
    fork
      begin
        for (int i = 2; i < 6; i++) begin
          a = 8'(i);
          send_word(a, w);
        end
      end
      begin
        step(3);
        ready_pct = 100;
      end
    join
    step(4);

    // Counter saturation and clear priority
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 8'(8 + $urandom_range(0, 119))
                                      : 8'(128 + $urandom_range(0, 119));
      send_word(a, w);
    end
    check("cnt_sat", 32'(bus.o_ovf_cnt), 32'(8'd255));
    bus.i_clr = 1'b1;
    send_word(8'h40, w);
    bus.i_clr = 1'b0;
    check("cnt_clr_wins", 32'(bus.o_ovf_cnt), 32'(8'd0));
    send_word(8'hA0, w);
    check("cnt_after_clr", 32'(bus.o_ovf_cnt), 32'(8'd1));
    step(3);

    // Asynchronous reset while the skid entry is occupied
    ready_pct = 0;
    step(2);
    send_word(8'h7F, w);
    send_word(8'h81, w);
    check("two_ready_low", 32'(bus.o_ready), 32'(1'b0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.o_valid), 32'(1'b0));
    check("arst_ready", 32'(bus.o_ready), 32'(1'b1));
    check("arst_cnt", 32'(bus.o_ovf_cnt), 32'(8'd0));
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    ready_pct = 100;
    step(2);
    send_word(8'h03, w);
    check("post_rst_lat", 32'(bus.o_valid), 32'(1'b1));
    check("post_rst_z", 32'({bus.o_Z, bus.o_ovf}), 32'({4'b0011, 1'b0}));
    step(2);

    // Random traffic with random backpressure, idle gaps and clears
    ready_pct = 60;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      bus.i_clr = ($urandom_range(0, 99) < 5);
      send_word(a, w);
      bus.i_clr = 1'b0;
      step($urandom_range(0, 2));
    end

    ready_pct = 100;
    bound = 0;
    while (exp_q.size() != 0 && bound < 100) begin
      step(1);
      bound++;
    end
    step(2);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sign_compressor.md
Name: sign_compressor

Overview:
- Registered signed-narrowing stage; the inverse of the team's 4-to-8-bit sign expander.
- Accepts IN_W-bit two's-complement words and emits OUT_W-bit words. Values that fit are passed unchanged; values that do not fit are saturated and flagged.
- Uses a valid/ready handshake on both sides with a 2-entry skid buffer, giving full throughput, plus a saturating overflow event counter.
- Sits after the arithmetic datapath, before narrow consumers.

Parameters:
- IN_W, 8, input word width in bits, signed; must be greater than OUT_W.
- OUT_W, 4, output word width in bits, signed; must be at least 2.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  stage can accept a word this cycle.
- i_A  input  IN_W  signed input word.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accepts the output word.
- o_Z  output  OUT_W  narrowed signed word.
- o_ovf  output  1  o_Z was clamped; qualified by o_valid.
- i_clr  input  1  synchronous clear of o_ovf_cnt.
- o_ovf_cnt  output  CNT_W  number of accepted words that overflowed; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0): o_valid=0, o_ready=1, o_Z=0, o_ovf=0, o_ovf_cnt=0, both buffer entries empty.
- Reset mid-transfer discards any buffered words; no output handshake completes while rst_n=0.
- Input handshake: a word is accepted when i_valid && o_ready at the rising edge.
- Output handshake: a word is consumed when o_valid && i_ready at the rising edge.
- Fit test: the top IN_W-OUT_W+1 bits of i_A are all equal.
  - Fit: o_Z = i_A[OUT_W-1:0] and o_ovf = 0.
  - No fit, i_A[IN_W-1]=0: o_Z = 0 followed by all ones (+max), o_ovf = 1.
  - No fit, i_A[IN_W-1]=1: o_Z = 1 followed by all zeros (-min), o_ovf = 1.
- The fit test and narrowing are computed combinationally at input acceptance. Results are stored as {Z, ovf} pairs.
- Latency: exactly 1 cycle from input acceptance to o_valid, when the stage is empty.
- Buffer states:
  - EMPTY: o_valid=0, o_ready=1. Accept goes to ONE.
  - ONE: output register valid, o_ready=1.
    - Accept and consume together: stay in ONE with the new word.
    - Consume only: go to EMPTY.
    - Accept only, with i_ready=0: new word goes to the skid entry; go to TWO.
  - TWO: o_ready=0. Consume moves the skid word into the output register; go to ONE.
- o_ready is driven from a register only, with no combinational path from i_ready.
- Ordering: strict FIFO. No word is dropped or duplicated.
- o_Z and o_ovf hold stable while o_valid=1 and i_ready=0.
- Counter:
  - Increments on each accepted word whose fit test fails.
  - Holds at 2^CNT_W-1 once reached; it never wraps.
  - i_clr=1 sets it to 0 on the next edge. If an overflow is accepted in the same cycle, the clear wins and the result is 0.

Optional Feature:
- Macro: SIGN_COMPRESSOR_WRAP_EN.
- Defined: overflowing words are truncated to i_A[OUT_W-1:0] instead of saturated. o_ovf and o_ovf_cnt behave exactly as in the saturating case.
- Undefined (default): saturating behaviour as specified above.

Test Plan:
- Fit range: IN_W=8, OUT_W=4, i_A=8'hF9 (-7) and 8'h05 with i_ready=1 -> o_Z=4'b1001 and 4'b0101, o_ovf=0, each 1 cycle after acceptance.
- Saturation: i_A=8'h08 -> o_Z=4'b0111, o_ovf=1. i_A=8'h80 -> o_Z=4'b1000, o_ovf=1. With WRAP_EN, the same inputs give 4'b1000 and 4'b0000 with o_ovf=1.
- Backpressure: stream 0..5 with i_ready=0 for 3 cycles -> o_ready falls after 2 accepts, o_Z holds 0. After release, outputs are 0,1,2,3,4,5 in order with no gaps once i_ready=1 steady.
- Full throughput: i_valid=1 and i_ready=1 for 16 cycles with sweep 8'hF8..8'h07 -> 16 outputs on 16 consecutive cycles, o_ready stays 1.
- Counter: 300 overflowing words -> o_ovf_cnt=255. Pulse i_clr together with an overflowing accept -> 0 next cycle, then 1 after the next overflow.
- Reset: assert rst_n=0 asynchronously while in TWO -> o_valid=0, o_ready=1, o_ovf_cnt=0 immediately, before the next clock edge. The first word after release appears with 1-cycle latency.
